// File: rtl/box_renderer.sv
// ---------------------------------------------------------------------------
// box_renderer
//
// Pixel-colour stage that sits directly after the VGA timing generator. It
// keeps a square box bouncing around the visible area (one move per frame),
// paints a white frame around the screen edge, and registers 12-bit RGB
// together with delayed sync so colour and sync leave the block aligned.
//
// Ports:
//   i_clk          system clock
//   i_rst_n        asynchronous active-low reset
//   i_pix_stb      pixel strobe; every piece of state advances only on it
//   i_x, i_y       current pixel column / line from the timing block
//   i_active       high while the pixel is in the visible area
//   i_screenend    end-of-frame flag, one strobe per frame
//   i_hs, i_vs     active-low sync from the timing block
//   i_pause        freezes box motion while high (colour path keeps running)
//   o_r, o_g, o_b  registered 4-bit colour channels
//   o_hs, o_vs     sync delayed by one strobe to line up with the colour
//   o_hit          one-clock pulse on any update that bounced off a wall
//   o_bounce_cnt   running count of wall hits, wraps 255 -> 0
// ---------------------------------------------------------------------------
module box_renderer #(
    parameter int H_RES    = 640,
    parameter int V_RES    = 480,
    parameter int BOX_SIZE = 32,
    parameter int X_INIT   = 100,
    parameter int Y_INIT   = 100,
    parameter int SPEED    = 2,
    parameter int BORDER   = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_pix_stb,
    input  logic [9:0] i_x,
    input  logic [8:0] i_y,
    input  logic       i_active,
    input  logic       i_screenend,
    input  logic       i_hs,
    input  logic       i_vs,
    input  logic       i_pause,
    output logic [3:0] o_r,
    output logic [3:0] o_g,
    output logic [3:0] o_b,
    output logic       o_hs,
    output logic       o_vs,
    output logic       o_hit,
    output logic [7:0] o_bounce_cnt
);

    // All position arithmetic is carried in 11 bits so that adding SPEED or
    // BOX_SIZE to the largest legal position can never wrap.
    localparam logic [10:0] X_MAX     = 11'(H_RES - BOX_SIZE);
    localparam logic [10:0] Y_MAX     = 11'(V_RES - BOX_SIZE);
    localparam logic [10:0] STEP      = 11'(SPEED);
    localparam logic [10:0] SIZE      = 11'(BOX_SIZE);
    localparam logic [10:0] BRD       = 11'(BORDER);
    localparam logic [10:0] BRD_RIGHT = 11'(H_RES - BORDER);
    localparam logic [10:0] BRD_LOW   = 11'(V_RES - BORDER);
    localparam logic [9:0]  X_RESET   = 10'(X_INIT);
    localparam logic [8:0]  Y_RESET   = 9'(Y_INIT);

    // Direction encodings: 1 = right / down, 0 = left / up.
    localparam logic DIR_RIGHT = 1'b1;
    localparam logic DIR_DOWN  = 1'b1;

    // Box state
    logic [9:0]  box_x;
    logic [8:0]  box_y;
    logic        dir_x;
    logic        dir_y;
    logic [1:0]  pal_idx;

    // Next-state values from the bounce logic
    logic [10:0] box_x_ext;
    logic [10:0] box_y_ext;
    logic [10:0] next_x;
    logic [10:0] next_y;
    logic        next_dir_x;
    logic        next_dir_y;
    logic        hit_x;
    logic        hit_y;
    logic [1:0]  hit_sum;
    logic        frame_update;

    // Colour path signals
    logic [10:0] pix_x_ext;
    logic [10:0] pix_y_ext;
    logic        in_box;
    logic        on_border;
    logic [11:0] pal_colour;
    logic [11:0] pix_colour;

    assign box_x_ext    = {1'b0, box_x};
    assign box_y_ext    = {2'b00, box_y};
    assign pix_x_ext    = {1'b0, i_x};
    assign pix_y_ext    = {2'b00, i_y};
    assign frame_update = i_pix_stb & i_screenend & ~i_pause;

    // Horizontal bounce: clamp to the wall and reverse when the next step
    // would carry the box past it.
    always_comb begin
        next_x     = box_x_ext;
        next_dir_x = dir_x;
        hit_x      = 1'b0;
        if (dir_x == DIR_RIGHT) begin
            if (box_x_ext + STEP > X_MAX) begin
                next_x     = X_MAX;
                next_dir_x = ~DIR_RIGHT;
                hit_x      = 1'b1;
            end else begin
                next_x = box_x_ext + STEP;
            end
        end else begin
            if (box_x_ext < STEP) begin
                next_x     = '0;
                next_dir_x = DIR_RIGHT;
                hit_x      = 1'b1;
            end else begin
                next_x = box_x_ext - STEP;
            end
        end
    end

    // Vertical bounce, same rules as the horizontal axis.
    always_comb begin
        next_y     = box_y_ext;
        next_dir_y = dir_y;
        hit_y      = 1'b0;
        if (dir_y == DIR_DOWN) begin
            if (box_y_ext + STEP > Y_MAX) begin
                next_y     = Y_MAX;
                next_dir_y = ~DIR_DOWN;
                hit_y      = 1'b1;
            end else begin
                next_y = box_y_ext + STEP;
            end
        end else begin
            if (box_y_ext < STEP) begin
                next_y     = '0;
                next_dir_y = DIR_DOWN;
                hit_y      = 1'b1;
            end else begin
                next_y = box_y_ext - STEP;
            end
        end
    end

    // A corner bounce counts as two hits but only one pulse / palette step.
    assign hit_sum = {1'b0, hit_x} + {1'b0, hit_y};

    // Box motion, hit pulse, hit counter and palette index. o_hit is
    // cleared on every clock that is not an update so it lasts one clock.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            box_x        <= X_RESET;
            box_y        <= Y_RESET;
            dir_x        <= DIR_RIGHT;
            dir_y        <= DIR_DOWN;
            pal_idx      <= 2'd0;
            o_hit        <= 1'b0;
            o_bounce_cnt <= 8'd0;
        end else begin
            o_hit <= 1'b0;
            if (frame_update) begin
                box_x        <= next_x[9:0];
                box_y        <= next_y[8:0];
                dir_x        <= next_dir_x;
                dir_y        <= next_dir_y;
                o_hit        <= hit_x | hit_y;
                o_bounce_cnt <= o_bounce_cnt + {6'd0, hit_sum};
                if (hit_x | hit_y) begin
                    pal_idx <= pal_idx + 2'd1;
                end
            end
        end
    end

    // Palette lookup
    always_comb begin
        pal_colour = 12'hF00;
        case (pal_idx)
            2'd0: pal_colour = 12'hF00;
            2'd1: pal_colour = 12'h0F0;
            2'd2: pal_colour = 12'h00F;
            2'd3: pal_colour = 12'hFF0;
            default: pal_colour = 12'hF00;
        endcase
    end

    // Pixel classification. The box position used here is the value held
    // before any update on the same clock.
    assign in_box = (pix_x_ext >= box_x_ext) && (pix_x_ext < box_x_ext + SIZE) &&
                    (pix_y_ext >= box_y_ext) && (pix_y_ext < box_y_ext + SIZE);

    assign on_border = (pix_x_ext < BRD) || (pix_x_ext >= BRD_RIGHT) ||
                       (pix_y_ext < BRD) || (pix_y_ext >= BRD_LOW);

    // Colour priority: blanking, then box, then border, then background.
    always_comb begin
        pix_colour = 12'h000;
        if (!i_active) begin
            pix_colour = 12'h000;
        end else if (in_box) begin
            pix_colour = pal_colour;
        end else if (on_border) begin
            pix_colour = 12'hFFF;
        end else begin
            pix_colour = 12'h000;
        end
    end

    // Output register: colour and sync move together on the strobe and hold
    // between strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_r  <= 4'h0;
            o_g  <= 4'h0;
            o_b  <= 4'h0;
            o_hs <= 1'b1;
            o_vs <= 1'b1;
        end else if (i_pix_stb) begin
            o_r  <= pix_colour[11:8];
            o_g  <= pix_colour[7:4];
            o_b  <= pix_colour[3:0];
            o_hs <= i_hs;
            o_vs <= i_vs;
        end
    end

endmodule

// File: tb/tb_box_renderer.sv
// ---------------------------------------------------------------------------
// tb_box_renderer
//
// Drives three box_renderer instances from shared inputs: a default one, one
// starting near the right wall (X_INIT=606) and one starting near the
// bottom-right corner (X_INIT=607, Y_INIT=447). Each pixel strobe queues the
// hand-computed colour for all three; a monitor pops and compares after the
// strobe's clock edge. Hit pulses and counts are compared directly after
// each frame-end strobe.
// ---------------------------------------------------------------------------
module tb_box_renderer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_stb = 1'b0;
    logic [9:0] x = '0;
    logic [8:0] y = '0;
    logic       active = 1'b0;
    logic       screenend = 1'b0;
    logic       hs = 1'b1;
    logic       vs = 1'b1;
    logic       pause = 1'b0;

    logic [3:0] r_o   [3];
    logic [3:0] g_o   [3];
    logic [3:0] b_o   [3];
    logic       hs_o  [3];
    logic       vs_o  [3];
    logic       hit_o [3];
    logic [7:0] cnt_o [3];

    typedef struct packed {
        logic [11:0] c0;
        logic [11:0] c1;
        logic [11:0] c2;
        logic        hs;
        logic        vs;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    box_renderer u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
        .i_active(active), .i_screenend(screenend), .i_hs(hs), .i_vs(vs),
        .i_pause(pause), .o_r(r_o[0]), .o_g(g_o[0]), .o_b(b_o[0]),
        .o_hs(hs_o[0]), .o_vs(vs_o[0]), .o_hit(hit_o[0]), .o_bounce_cnt(cnt_o[0])
    );

    box_renderer #(.X_INIT(606)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
        .i_active(active), .i_screenend(screenend), .i_hs(hs), .i_vs(vs),
        .i_pause(pause), .o_r(r_o[1]), .o_g(g_o[1]), .o_b(b_o[1]),
        .o_hs(hs_o[1]), .o_vs(vs_o[1]), .o_hit(hit_o[1]), .o_bounce_cnt(cnt_o[1])
    );

    box_renderer #(.X_INIT(607), .Y_INIT(447)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(pix_stb), .i_x(x), .i_y(y),
        .i_active(active), .i_screenend(screenend), .i_hs(hs), .i_vs(vs),
        .i_pause(pause), .o_r(r_o[2]), .o_g(g_o[2]), .o_b(b_o[2]),
        .o_hs(hs_o[2]), .o_vs(vs_o[2]), .o_hit(hit_o[2]), .o_bounce_cnt(cnt_o[2])
    );

    // One comparison: count it, report it if it disagrees.
    task automatic checkOutput(input string name, input logic [11:0] act,
                               input logic [11:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // One pixel strobe; the expected colour of each instance is queued.
    task automatic applyStimulus(input int px, input int py, input logic act,
                                 input logic se, input logic h, input logic v,
                                 input logic [11:0] e0, input logic [11:0] e1,
                                 input logic [11:0] e2);
        exp_t e;
        @(negedge clk);
        x         = 10'(px);
        y         = 9'(py);
        active    = act;
        screenend = se;
        hs        = h;
        vs        = v;
        pix_stb   = 1'b1;
        e.c0 = e0;
        e.c1 = e1;
        e.c2 = e2;
        e.hs = h;
        e.vs = v;
        exp_q.push_back(e);
        @(posedge clk);
        #2;
        pix_stb   = 1'b0;
        screenend = 1'b0;
    endtask

    // Frame-end strobe (blanked, so colour is black) followed by hit/count
    // checks and a check that the hit pulse is gone one clock later.
    task automatic frameEnd(input logic [2:0] eh, input int c0, input int c1,
                            input int c2);
        applyStimulus(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 12'h000, 12'h000, 12'h000);
        checkOutput("hit0", {11'd0, hit_o[0]}, {11'd0, eh[0]});
        checkOutput("hit1", {11'd0, hit_o[1]}, {11'd0, eh[1]});
        checkOutput("hit2", {11'd0, hit_o[2]}, {11'd0, eh[2]});
        checkOutput("cnt0", {4'd0, cnt_o[0]}, 12'(c0));
        checkOutput("cnt1", {4'd0, cnt_o[1]}, 12'(c1));
        checkOutput("cnt2", {4'd0, cnt_o[2]}, 12'(c2));
        @(posedge clk);
        #1;
        checkOutput("hit_pulse_end",
                    {9'd0, hit_o[2], hit_o[1], hit_o[0]}, 12'h000);
    endtask

    // Scoreboard monitor: every strobe taken out of reset must have a queued
    // expectation, compared just after the edge that registers it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            if (rst_n && pix_stb) begin
                #1;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL sb_underflow: got strobe, expected none");
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("rgb0", {r_o[0], g_o[0], b_o[0]}, e.c0);
                    checkOutput("rgb1", {r_o[1], g_o[1], b_o[1]}, e.c1);
                    checkOutput("rgb2", {r_o[2], g_o[2], b_o[2]}, e.c2);
                    checkOutput("hs", {11'd0, hs_o[0]}, {11'd0, e.hs});
                    checkOutput("vs", {11'd0, vs_o[0]}, {11'd0, e.vs});
                end
            end
        end
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("rst_rgb", {r_o[i], g_o[i], b_o[i]}, 12'h000);
            checkOutput("rst_sync", {10'd0, hs_o[i], vs_o[i]}, 12'h003);
            checkOutput("rst_hit", {11'd0, hit_o[i]}, 12'h000);
            checkOutput("rst_cnt", {4'd0, cnt_o[i]}, 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Colour classification before any motion
        applyStimulus(110, 110, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);
        applyStimulus(2,   200, 1, 0, 0, 1, 12'hFFF, 12'hFFF, 12'hFFF);
        // Outputs hold while there is no strobe
        @(negedge clk);
        x = 10'd300;
        @(posedge clk);
        #1;
        checkOutput("hold_rgb", {r_o[0], g_o[0], b_o[0]}, 12'hFFF);
        checkOutput("hold_hs", {11'd0, hs_o[0]}, 12'h000);
        applyStimulus(300, 300, 1, 0, 1, 0, 12'h000, 12'h000, 12'h000);
        applyStimulus(110, 110, 0, 0, 1, 1, 12'h000, 12'h000, 12'h000);

        // Frame 1: dut2 hits a corner (two hits, one pulse, palette +1)
        frameEnd(3'b100, 0, 0, 2);
        applyStimulus(101, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(102, 110, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);
        applyStimulus(133, 133, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);
        applyStimulus(134, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(607, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(608, 110, 1, 0, 1, 1, 12'h000, 12'hF00, 12'h000);
        applyStimulus(608, 448, 1, 0, 1, 1, 12'h000, 12'h000, 12'h0F0);
        applyStimulus(608, 447, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(639, 479, 1, 0, 1, 1, 12'hFFF, 12'hFFF, 12'h0F0);

        // Frame 2: dut1 hits the right wall
        frameEnd(3'b010, 0, 1, 2);
        applyStimulus(608, 110, 1, 0, 1, 1, 12'h000, 12'h0F0, 12'h000);
        applyStimulus(103, 103, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(104, 104, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);

        // Frame 3: dut1 moves back left
        frameEnd(3'b000, 0, 1, 2);
        applyStimulus(606, 110, 1, 0, 1, 1, 12'h000, 12'h0F0, 12'h000);
        applyStimulus(605, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);

        // Paused frames leave everything where it was
        pause = 1'b1;
        for (int i = 0; i < 3; i++) frameEnd(3'b000, 0, 1, 2);
        applyStimulus(105, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(106, 110, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);
        applyStimulus(604, 444, 1, 0, 1, 1, 12'h000, 12'h000, 12'h0F0);
        applyStimulus(603, 444, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        @(negedge clk);
        pause = 1'b0;
        frameEnd(3'b000, 0, 1, 2);
        applyStimulus(107, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(108, 110, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);
        applyStimulus(604, 110, 1, 0, 1, 1, 12'h000, 12'h0F0, 12'h000);
        applyStimulus(603, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(602, 442, 1, 0, 1, 1, 12'h000, 12'h000, 12'h0F0);

        // Asynchronous reset in the middle of a frame
        applyStimulus(2, 200, 1, 0, 0, 0, 12'hFFF, 12'hFFF, 12'hFFF);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            checkOutput("async_rgb", {r_o[i], g_o[i], b_o[i]}, 12'h000);
            checkOutput("async_sync", {10'd0, hs_o[i], vs_o[i]}, 12'h003);
            checkOutput("async_cnt", {4'd0, cnt_o[i]}, 12'h000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_hit",
                    {9'd0, hit_o[2], hit_o[1], hit_o[0]}, 12'h000);
        frameEnd(3'b100, 0, 0, 2);
        applyStimulus(101, 110, 1, 0, 1, 1, 12'h000, 12'h000, 12'h000);
        applyStimulus(102, 110, 1, 0, 1, 1, 12'hF00, 12'h000, 12'h000);
        applyStimulus(608, 110, 1, 0, 1, 1, 12'h000, 12'hF00, 12'h000);
        applyStimulus(608, 448, 1, 0, 1, 1, 12'h000, 12'h000, 12'h0F0);

        // Every queued expectation must have been consumed
        repeat (3) @(posedge clk);
        #1;
        checkOutput("sb_leftover", 12'(exp_q.size()), 12'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
